// File: rtl/layered_objects_mux.sv
// Pipelined priority compositor for the VGA path: NUM_LAYERS layers plus background,
// with colour-key transparency, frame-synchronous enables, blink and hit-flash effects.
module layered_objects_mux #(
    parameter int                NUM_LAYERS   = 14,
    parameter int                RGB_W        = 8,
    parameter logic [RGB_W-1:0]  TRANSPARENT  = 8'hFF,
    parameter int                BLINK_PERIOD = 16,
    parameter int                FLASH_FRAMES = 8,
    parameter logic [RGB_W-1:0]  FLASH_RGB    = 8'hE0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            startOfFrame,
    input  logic [NUM_LAYERS-1:0]           layer_en,
    input  logic [NUM_LAYERS-1:0]           blink_mask,
    input  logic [NUM_LAYERS-1:0]           flash_req,
    input  logic [NUM_LAYERS-1:0]           layerDR,
    input  logic [NUM_LAYERS*RGB_W-1:0]     layerRGB,
    input  logic [RGB_W-1:0]                bgRGB,
    output logic [RGB_W-1:0]                RGBOut,
    output logic [$clog2(NUM_LAYERS+1)-1:0] topLayer
);

    localparam int                TOP_W      = $clog2(NUM_LAYERS + 1);
    localparam int                FC_W       = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [FC_W-1:0]   FC_LAST    = FC_W'(BLINK_PERIOD - 1);
    localparam logic [7:0]        FLASH_LOAD = 8'(FLASH_FRAMES);

    logic [NUM_LAYERS-1:0]       en_q;
    logic [NUM_LAYERS-1:0]       blink_q;
    logic [FC_W-1:0]             frame_cnt;
    logic                        blink_phase;
    logic [7:0]                  flash_cnt [NUM_LAYERS];

    logic [NUM_LAYERS-1:0]       eligible;
    logic [NUM_LAYERS-1:0]       flashing;

    logic [NUM_LAYERS-1:0]       elig_q;
    logic [NUM_LAYERS-1:0]       flash_q;
    logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0]            bg_q;

    logic [TOP_W-1:0]            win_idx;
    logic [RGB_W-1:0]            win_rgb;

    // Enables and blink mask are shadowed so a mid-frame change never tears a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q        <= '1;
            blink_q     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (startOfFrame) begin
            en_q    <= layer_en;
            blink_q <= blink_mask;
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // NOTE: the flash counters are effect state, not storage, so they must clear on reset
    // like any other register; only true data memories are left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) flash_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (flash_req[i])
                    flash_cnt[i] <= FLASH_LOAD;
                else if (startOfFrame && flash_cnt[i] != 8'd0)
                    flash_cnt[i] <= flash_cnt[i] - 8'd1;
            end
        end
    end

    // NOTE: combinational blocks use blocking assignments and give every output a default
    // first, so no path through the block can leave a latch behind.
    always_comb begin
        eligible = '0;
        flashing = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            flashing[i] = (flash_cnt[i] != 8'd0);
            eligible[i] = layerDR[i] & en_q[i] & ~(blink_q[i] & blink_phase)
                        & (layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elig_q  <= '0;
            flash_q <= '0;
            rgb_q   <= '0;
            bg_q    <= '0;
        end else begin
            elig_q  <= eligible;
            flash_q <= flashing;
            rgb_q   <= layerRGB;
            bg_q    <= bgRGB;
        end
    end

    // Scan from lowest priority upward so the lowest-index eligible layer wins.
    always_comb begin
        win_idx = TOP_W'(NUM_LAYERS);
        win_rgb = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (elig_q[i]) begin
                win_idx = TOP_W'(i);
                win_rgb = flash_q[i] ? FLASH_RGB : rgb_q[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RGBOut   <= '0;
            topLayer <= TOP_W'(NUM_LAYERS);
        end else begin
            RGBOut   <= win_rgb;
            topLayer <= win_idx;
        end
    end

endmodule

// File: tb/tb_layered_objects_mux.sv
// Self-checking bench for layered_objects_mux: frame-level reference model compared every
// cycle, plus directed vectors with hand-computed expected pixels.
module tb_layered_objects_mux;

    localparam int N     = 14;
    localparam int W     = 8;
    localparam int TOP_W = 4;
    localparam int BP    = 16;
    localparam int FF    = 8;

    typedef struct packed {
        logic [W-1:0]     rgb;
        logic [TOP_W-1:0] top;
    } pix_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             startOfFrame;
    logic [N-1:0]     layer_en;
    logic [N-1:0]     blink_mask;
    logic [N-1:0]     flash_req;
    logic [N-1:0]     layerDR;
    logic [N*W-1:0]   layerRGB;
    logic [W-1:0]     bgRGB;
    logic [W-1:0]     RGBOut;
    logic [TOP_W-1:0] topLayer;

    int n_tests = 0;
    int n_fail  = 0;

    layered_objects_mux dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .layer_en     (layer_en),
        .blink_mask   (blink_mask),
        .flash_req    (flash_req),
        .layerDR      (layerDR),
        .layerRGB     (layerRGB),
        .bgRGB        (bgRGB),
        .RGBOut       (RGBOut),
        .topLayer     (topLayer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got_rgb, input logic [TOP_W-1:0] got_top,
                         input logic [W-1:0] exp_rgb, input logic [TOP_W-1:0] exp_top);
        n_tests++;
        if (got_rgb !== exp_rgb || got_top !== exp_top) begin
            n_fail++;
            $display("FAIL %s t=%0t: got rgb=%h top=%0d, expected rgb=%h top=%0d",
                     name, $time, got_rgb, got_top, exp_rgb, exp_top);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    int           sof_cnt;          // frames started since reset
    logic [N-1:0] en_m, blink_m;
    bit           fl_active [N];
    int           fl_frame  [N];    // frame index in which the flash count was (re)loaded
    pix_t         pipe_exp, out_exp;

    function automatic pix_t model_pixel(input logic [N-1:0] dr, input logic [N*W-1:0] rgbs,
                                         input logic [W-1:0] bg, input logic [N-1:0] en,
                                         input logic [N-1:0] bl, input int frames,
                                         input logic [N-1:0] fl);
        pix_t p;
        bit   hidden_phase;
        logic [W-1:0] c;
        hidden_phase = ((frames / BP) % 2) == 1;
        p.rgb = bg;
        p.top = TOP_W'(N);
        for (int i = N - 1; i >= 0; i--) begin
            c = rgbs[i*W +: W];
            if (dr[i] && en[i] && !(bl[i] && hidden_phase) && c != 8'hFF) begin
                p.rgb = fl[i] ? 8'hE0 : c;
                p.top = TOP_W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [N-1:0] model_flashing(input int frames);
        logic [N-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++)
            f[i] = fl_active[i] && ((frames - fl_frame[i]) < FF);
        return f;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sof_cnt  <= 0;
            en_m     <= '1;
            blink_m  <= '0;
            pipe_exp <= '{rgb: '0, top: TOP_W'(N)};
            out_exp  <= '{rgb: '0, top: TOP_W'(N)};
            for (int i = 0; i < N; i++) begin
                fl_active[i] <= 1'b0;
                fl_frame[i]  <= 0;
            end
        end else begin
            out_exp  <= pipe_exp;
            pipe_exp <= model_pixel(layerDR, layerRGB, bgRGB, en_m, blink_m, sof_cnt,
                                    model_flashing(sof_cnt));
            if (startOfFrame) begin
                sof_cnt <= sof_cnt + 1;
                en_m    <= layer_en;
                blink_m <= blink_mask;
            end
            for (int i = 0; i < N; i++) begin
                if (flash_req[i]) begin
                    fl_active[i] <= 1'b1;
                    fl_frame[i]  <= startOfFrame ? sof_cnt + 1 : sof_cnt;
                end
            end
        end
    end

    // Cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (reset !== 1'bx)
            check("model", RGBOut, topLayer, out_exp.rgb, out_exp.top);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(3);
    endtask

    task automatic set_rgb(input int i, input logic [W-1:0] v);
        layerRGB[i*W +: W] = v;
    endtask

    initial begin
        startOfFrame = 1'b0;
        layer_en     = '1;
        blink_mask   = '0;
        flash_req    = '0;
        layerDR      = '0;
        layerRGB     = '0;
        bgRGB        = 8'h92;
        #1 reset = 1'b1;
        tick(3);
        check("reset_state", RGBOut, topLayer, 8'h00, 4'd14);
        reset = 1'b0;
        frame();

        // Priority
        layerDR = '0; layerDR[3] = 1'b1; layerDR[5] = 1'b1; layerDR[12] = 1'b1;
        set_rgb(3, 8'h1C); set_rgb(5, 8'h03); set_rgb(12, 8'h50);
        tick(2);
        check("prio_3", RGBOut, topLayer, 8'h1C, 4'd3);
        layerDR[3] = 1'b0;
        tick(2);
        check("prio_5", RGBOut, topLayer, 8'h03, 4'd5);

        // Transparency and background
        layerDR = '0; layerDR[0] = 1'b1; layerDR[1] = 1'b1;
        set_rgb(0, 8'hFF); set_rgb(1, 8'h44);
        tick(2);
        check("transparent", RGBOut, topLayer, 8'h44, 4'd1);
        layerDR = '0;
        tick(2);
        check("background", RGBOut, topLayer, 8'h92, 4'd14);

        // Frame-synchronous enable
        layerDR = '0; layerDR[2] = 1'b1; set_rgb(2, 8'h2A);
        tick(2);
        check("en_before", RGBOut, topLayer, 8'h2A, 4'd2);
        layer_en[2] = 1'b0;
        tick(5);
        check("en_midframe", RGBOut, topLayer, 8'h2A, 4'd2);
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(1);
        check("en_sof_pixel", RGBOut, topLayer, 8'h2A, 4'd2);
        tick(1);
        check("en_after_sof", RGBOut, topLayer, 8'h92, 4'd14);
        layer_en = '1;
        frame();

        // Blink, from a fresh frame counter
        tick(1);
        #2 reset = 1'b1;
        tick(1);
        reset = 1'b0;
        layerDR = '0; layerDR[4] = 1'b1; set_rgb(4, 8'h33);
        blink_mask = '0; blink_mask[4] = 1'b1;
        repeat (15) frame();
        check("blink_vis15", RGBOut, topLayer, 8'h33, 4'd4);
        frame();
        check("blink_hid16", RGBOut, topLayer, 8'h92, 4'd14);
        repeat (15) frame();
        check("blink_hid31", RGBOut, topLayer, 8'h92, 4'd14);
        frame();
        check("blink_vis32", RGBOut, topLayer, 8'h33, 4'd4);

        // Flash
        blink_mask = '0;
        frame();
        layerDR = '0; layerDR[6] = 1'b1; set_rgb(6, 8'h0F);
        tick(2);
        check("flash_before", RGBOut, topLayer, 8'h0F, 4'd6);
        flash_req[6] = 1'b1;
        tick(1);
        flash_req[6] = 1'b0;
        tick(2);
        check("flash_on", RGBOut, topLayer, 8'hE0, 4'd6);
        set_rgb(6, 8'hFF);
        tick(2);
        check("flash_transp", RGBOut, topLayer, 8'h92, 4'd14);
        set_rgb(6, 8'h0F);
        repeat (7) frame();
        check("flash_last", RGBOut, topLayer, 8'hE0, 4'd6);
        frame();
        check("flash_off", RGBOut, topLayer, 8'h0F, 4'd6);

        // Flash request coincident with startOfFrame: load wins
        flash_req[6] = 1'b1;
        startOfFrame = 1'b1;
        tick(1);
        flash_req[6] = 1'b0;
        startOfFrame = 1'b0;
        tick(3);
        repeat (7) frame();
        check("flash_sof_7", RGBOut, topLayer, 8'hE0, 4'd6);
        frame();
        check("flash_sof_8", RGBOut, topLayer, 8'h0F, 4'd6);

        // Reset mid-line with an active flash and a pending disable
        flash_req[6] = 1'b1;
        tick(1);
        flash_req[6] = 1'b0;
        layer_en = '0;
        tick(3);
        #2 reset = 1'b1;
        #1 check("reset_async", RGBOut, topLayer, 8'h00, 4'd14);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("reset_rel_1", RGBOut, topLayer, 8'h00, 4'd14);
        tick(1);
        check("reset_rel_2", RGBOut, topLayer, 8'h0F, 4'd6);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
